exception_ctrl: RTL
===================

Name: exception_ctrl

Overview:
- Drives flush requests into the ID/EX, IF/ID and EX/MEM pipeline registers, so it sits on the other end of the ID_EX_Flush_excep interface.
- Detects arithmetic overflow from EX and reserved/undefined opcodes from ID.
- Captures EPC and Cause, redirects the PC to the exception vector, masks further exceptions until ERET, then returns to EPC.

Parameters:
- VECTOR, 32'h8000_0180, exception handler entry address.
- CAUSE_OV, 5'd12, ExcCode for arithmetic overflow.
- CAUSE_RI, 5'd10, ExcCode for reserved instruction.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Overflow  input  1  ALU overflow for the instruction currently in EX; valid only when EX is signed arithmetic.
- ExPCPlus4  input  32  PCPlus4Reg of the instruction in EX.
- Undef  input  1  decoder flags a reserved opcode in ID.
- IdPCPlus4  input  32  PC+4 of the instruction in ID.
- Eret  input  1  ERET decoded in ID.
- IF_ID_Flush  output  1  zero the IF/ID register at the next edge.
- ID_EX_Flush_excep  output  1  bubble ID/EX (control fields to 0) at the next edge.
- EX_MEM_Flush  output  1  bubble EX/MEM at the next edge.
- PCSrcExcep  output  1  PC loads PCExcep at the next edge instead of its normal next value.
- PCExcep  output  32  redirect target.
- EPC  output  32  address of the faulting instruction.
- Cause  output  32  Cause[6:2] = ExcCode; all other bits 0.
- EXL  output  1  exception level; 1 while in the handler.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; EPC = 0; Cause = 0; EXL = 0. All flush outputs and PCSrcExcep are 0 while reset is asserted.
- States:
  - IDLE (EXL = 0).
  - HANDLER (EXL = 1).
  - EXL is a registered copy of the state.
- IDLE, Overflow = 1, taken in cycle T:
  - Same cycle, combinationally: IF_ID_Flush = ID_EX_Flush_excep = EX_MEM_Flush = PCSrcExcep = 1; PCExcep = VECTOR.
  - Edge ending T: EPC <= ExPCPlus4 - 4; Cause[6:2] <= CAUSE_OV; state -> HANDLER.
- IDLE, Undef = 1 and Overflow = 0:
  - Same cycle: IF_ID_Flush = ID_EX_Flush_excep = PCSrcExcep = 1; EX_MEM_Flush = 0; PCExcep = VECTOR.
  - Edge ending T: EPC <= IdPCPlus4 - 4; Cause[6:2] <= CAUSE_RI; state -> HANDLER.
- Priority: Overflow and Undef together -> overflow wins, because EX is the older instruction. The ID instruction is flushed and its Undef is lost.
- IDLE, Eret = 1: ignored. No redirect, no flush, no state change.
- HANDLER:
  - Overflow and Undef are masked; no flush, no EPC/Cause update.
  - Eret = 1: same cycle PCSrcExcep = 1, PCExcep = EPC, IF_ID_Flush = 1, other flushes 0. Next edge: state -> IDLE.
  - Eret together with Overflow/Undef: Eret is handled, the exception is ignored.
- Address arithmetic: subtraction is modulo 2^32. ExPCPlus4 = 0 gives EPC = 32'hFFFF_FFFC.
- Latency: detection to redirect is 0 cycles (combinational). Registered state is visible 1 cycle later.
- Reset asserted mid-HANDLER: returns to IDLE immediately; EPC and Cause are cleared.

Optional Feature:
- Macro EXCEP_COUNT_EN.
- Defined:
  - Adds output ExcCount [15:0]: increments on every taken exception, saturates at 16'hFFFF, reset to 0.
  - Adds output MaskedCount [15:0]: increments each cycle Overflow or Undef is high while in HANDLER, saturates at 16'hFFFF, reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package `mips_excep_pkg`:
  - Cause codes CAUSE_OV and CAUSE_RI.
  - Default VECTOR.
  - State encoding IDLE = 1'b0, HANDLER = 1'b1.
- One natural sub-module, `excep_prio_enc`: combinational; takes Overflow, Undef and EXL; outputs take, is_ov, and ExcCode.

Test Plan:
- Overflow = 1, ExPCPlus4 = 32'h0000_0044 in IDLE -> same cycle: all three flushes = 1, PCExcep = 32'h8000_0180. Next cycle: EPC = 32'h0000_0040, Cause = 32'h0000_0030, EXL = 1.
- Undef = 1, IdPCPlus4 = 32'h0000_0100 -> IF_ID/ID_EX flush = 1, EX_MEM_Flush = 0. Next cycle: EPC = 32'h0000_00FC, Cause = 32'h0000_0028.
- Overflow and Undef together, ExPCPlus4 = 32'h20, IdPCPlus4 = 32'h24 -> EPC = 32'h1C, Cause code = 12.
- In HANDLER, pulse Overflow -> no flush, EPC unchanged. Then Eret -> PCSrcExcep = 1, PCExcep = EPC, IF_ID_Flush = 1; next cycle EXL = 0.
- Eret in IDLE -> all outputs remain 0.
- Assert reset while EXL = 1 -> EXL, EPC and Cause are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_excep_pkg.sv
// Shared exception definitions: cause codes, default handler vector, and controller state encoding.
package mips_excep_pkg;

  localparam logic [31:0] DEFAULT_VECTOR = 32'h8000_0180;
  localparam logic [4:0]  CAUSE_OV       = 5'd12;
  localparam logic [4:0]  CAUSE_RI       = 5'd10;

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } excep_state_e;

endpackage

// File: rtl/excep_prio_enc.sv
// Exception priority encoder: EX overflow beats ID reserved-opcode; everything is masked while EXL is set.
module excep_prio_enc
  import mips_excep_pkg::*;
#(
  parameter logic [4:0] CODE_OV = mips_excep_pkg::CAUSE_OV,
  parameter logic [4:0] CODE_RI = mips_excep_pkg::CAUSE_RI
) (
  input  logic       overflow,
  input  logic       undef,
  input  logic       exl,
  output logic       take,
  output logic       is_ov,
  output logic [4:0] exc_code
);

  always_comb begin
    take     = ~exl & (overflow | undef);
    is_ov    = ~exl & overflow;
    exc_code = overflow ? CODE_OV : CODE_RI;
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: flushes the pipeline, captures EPC/Cause, redirects to the handler, returns on ERET.
// Optional event counters (ExcCount, MaskedCount) are enabled with `define EXCEP_COUNT_EN.
module exception_ctrl
  import mips_excep_pkg::*;
#(
  parameter logic [31:0] VECTOR   = mips_excep_pkg::DEFAULT_VECTOR,
  parameter logic [4:0]  CAUSE_OV = mips_excep_pkg::CAUSE_OV,
  parameter logic [4:0]  CAUSE_RI = mips_excep_pkg::CAUSE_RI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Overflow,
  input  logic [31:0] ExPCPlus4,
  input  logic        Undef,
  input  logic [31:0] IdPCPlus4,
  input  logic        Eret,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush_excep,
  output logic        EX_MEM_Flush,
  output logic        PCSrcExcep,
  output logic [31:0] PCExcep,
  output logic [31:0] EPC,
  output logic [31:0] Cause,
`ifdef EXCEP_COUNT_EN
  output logic [15:0] ExcCount,
  output logic [15:0] MaskedCount,
`endif
  output logic        EXL
);

  excep_state_e state, state_next;
  logic         take, is_ov;
  logic [4:0]   exc_code;
  logic [4:0]   cause_code;

  excep_prio_enc #(
    .CODE_OV (CAUSE_OV),
    .CODE_RI (CAUSE_RI)
  ) u_prio (
    .overflow (Overflow),
    .undef    (Undef),
    .exl      (EXL),
    .take     (take),
    .is_ov    (is_ov),
    .exc_code (exc_code)
  );

  assign EXL   = (state == HANDLER);
  assign Cause = {25'd0, cause_code, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      EPC        <= '0;
      cause_code <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        EPC        <= (is_ov ? ExPCPlus4 : IdPCPlus4) - 32'd4;
        cause_code <= exc_code;
      end
    end
  end

  // Redirect/flush are combinational so detection and redirect share a cycle; reset gates them off.
  always_comb begin
    state_next        = state;
    IF_ID_Flush       = 1'b0;
    ID_EX_Flush_excep = 1'b0;
    EX_MEM_Flush      = 1'b0;
    PCSrcExcep        = 1'b0;
    PCExcep           = VECTOR;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (take) begin
            IF_ID_Flush       = 1'b1;
            ID_EX_Flush_excep = 1'b1;
            EX_MEM_Flush      = is_ov;
            PCSrcExcep        = 1'b1;
            state_next        = HANDLER;
          end
        end
        HANDLER: begin
          if (Eret) begin
            IF_ID_Flush = 1'b1;
            PCSrcExcep  = 1'b1;
            PCExcep     = EPC;
            state_next  = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef EXCEP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ExcCount    <= '0;
      MaskedCount <= '0;
    end else begin
      if (take && ExcCount != '1)
        ExcCount <= ExcCount + 16'd1;
      if (EXL && (Overflow || Undef) && MaskedCount != '1)
        MaskedCount <= MaskedCount + 16'd1;
    end
  end
`endif

endmodule
